// File: rtl/ubus_pkg.sv
// Shared UBUS types: transfer size encoding, slave FSM states and a beat-count helper.
package ubus_pkg;

    typedef enum logic [1:0] {
        SIZE_1 = 2'b00,
        SIZE_2 = 2'b01,
        SIZE_4 = 2'b10,
        SIZE_8 = 2'b11
    } ubus_size_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA,
        DRAIN
    } ubus_slave_state_e;

    function automatic logic [3:0] ubus_beats(input ubus_size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/ubus_slave_mem_array.sv
// Byte-wide single-port RAM behind the UBUS slave: synchronous write, asynchronous read, no reset.
module ubus_slave_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ubus_slave_mem.sv
// UBUS slave responder backing one address window with a byte memory.
// Define UBUS_SLAVE_STATS_EN to add the saturating read/write/error statistics outputs.
module ubus_slave_mem
    import ubus_pkg::*;
#(
    parameter logic [15:0] ADDR_LO     = 16'h0000,
    parameter logic [15:0] ADDR_HI     = 16'h7FFF,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        ubus_clock,
    input  logic        ubus_reset_n,
    input  logic        ubus_start,
    input  logic [15:0] ubus_addr,
    input  logic [1:0]  ubus_size,
    input  logic        ubus_read,
    input  logic        ubus_write,
    input  logic        ubus_bip,
    inout  wire  [7:0]  ubus_data,
    output wire         ubus_wait,
    output wire         ubus_error
`ifdef UBUS_SLAVE_STATS_EN
    ,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_err_cnt
`endif
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES - 1);

    ubus_slave_state_e r_state;
    logic [3:0]        r_beats;
    logic [2:0]        r_beat;
    logic [AW-1:0]     r_idx;
    logic [2:0]        r_waitCnt;
    logic              r_isRead;
    logic              r_isWrite;
    logic              r_drive;
    logic              r_waitOut;
    logic              r_errOut;
    logic              r_rdEn;

    logic [15:0]       w_offset;
    logic              w_inWindow;
    logic              w_lastBeat;
    logic              w_memWe;
    logic [7:0]        w_rdData;

    // Offset-based decode keeps the window test a single unsigned compare.
    assign w_offset   = ubus_addr - ADDR_LO;
    assign w_inWindow = (w_offset <= (ADDR_HI - ADDR_LO));
    assign w_lastBeat = ({1'b0, r_beat} == (r_beats - 4'd1));
    assign w_memWe    = ubus_reset_n && (r_state == DATA) && r_isWrite;

    ubus_slave_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clock (ubus_clock),
        .i_we    (w_memWe),
        .i_addr  (r_idx),
        .i_wdata (ubus_data),
        .o_rdata (w_rdData)
    );

    always_ff @(posedge ubus_clock) begin
        if (!ubus_reset_n) begin
            r_state   <= IDLE;
            r_beats   <= 4'd0;
            r_beat    <= 3'd0;
            r_idx     <= '0;
            r_waitCnt <= 3'd0;
            r_isRead  <= 1'b0;
            r_isWrite <= 1'b0;
            r_drive   <= 1'b0;
            r_waitOut <= 1'b0;
            r_errOut  <= 1'b0;
            r_rdEn    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ubus_start) begin
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    r_beats   <= ubus_beats(ubus_size_e'(ubus_size));
                    r_beat    <= 3'd0;
                    r_idx     <= w_offset[AW-1:0];
                    r_isRead  <= ubus_read;
                    r_isWrite <= ubus_write;
                    if (!(ubus_read || ubus_write) || !w_inWindow) begin
                        r_state <= IDLE;
                    end else if (ubus_read && ubus_write) begin
                        r_state   <= DRAIN;
                        r_drive   <= 1'b1;
                        r_waitOut <= 1'b0;
                        r_errOut  <= 1'b1;
                    end else if (WAIT_CYCLES > 0) begin
                        r_state   <= WAIT;
                        r_drive   <= 1'b1;
                        r_waitOut <= 1'b1;
                        r_errOut  <= 1'b0;
                        r_waitCnt <= WAIT_INIT;
                    end else begin
                        r_state   <= DATA;
                        r_drive   <= 1'b1;
                        r_waitOut <= 1'b0;
                        r_errOut  <= 1'b0;
                        r_rdEn    <= ubus_read;
                    end
                end
                WAIT: begin
                    if (r_waitCnt == 3'd0) begin
                        r_state   <= DATA;
                        r_waitOut <= 1'b0;
                        r_rdEn    <= r_isRead;
                    end else begin
                        r_waitCnt <= r_waitCnt - 3'd1;
                    end
                end
                DATA: begin
                    r_beat <= r_beat + 3'd1;
                    r_idx  <= r_idx + 1'b1;
                    // A bip/last-beat disagreement is an early end or an overrun.
                    if (!ubus_bip && w_lastBeat) begin
                        r_state <= IDLE;
                        r_drive <= 1'b0;
                        r_rdEn  <= 1'b0;
                    end else if (!ubus_bip || w_lastBeat) begin
                        r_state  <= DRAIN;
                        r_errOut <= 1'b1;
                        r_rdEn   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!ubus_bip) begin
                        r_state  <= IDLE;
                        r_drive  <= 1'b0;
                        r_errOut <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_drive <= 1'b0;
                    r_rdEn  <= 1'b0;
                end
            endcase
        end
    end

    assign ubus_wait  = r_drive ? r_waitOut : 1'bz;
    assign ubus_error = r_drive ? r_errOut  : 1'bz;
    assign ubus_data  = r_rdEn  ? w_rdData  : 8'bz;

`ifdef UBUS_SLAVE_STATS_EN
    logic [15:0] r_statRd;
    logic [15:0] r_statWr;
    logic [15:0] r_statErr;
    logic        w_doneOk;
    logic        w_toDrain;

    assign w_doneOk  = (r_state == DATA) && !ubus_bip && w_lastBeat;
    assign w_toDrain = ((r_state == ADDR) && ubus_read && ubus_write && w_inWindow)
                    || ((r_state == DATA) && ((!ubus_bip) ^ w_lastBeat));

    always_ff @(posedge ubus_clock) begin
        if (!ubus_reset_n) begin
            r_statRd  <= 16'd0;
            r_statWr  <= 16'd0;
            r_statErr <= 16'd0;
        end else begin
            if (w_doneOk && r_isRead && (r_statRd != 16'hFFFF)) begin
                r_statRd <= r_statRd + 16'd1;
            end
            if (w_doneOk && r_isWrite && (r_statWr != 16'hFFFF)) begin
                r_statWr <= r_statWr + 16'd1;
            end
            if (w_toDrain && (r_statErr != 16'hFFFF)) begin
                r_statErr <= r_statErr + 16'd1;
            end
        end
    end

    assign stat_rd_cnt  = r_statRd;
    assign stat_wr_cnt  = r_statWr;
    assign stat_err_cnt = r_statErr;
`endif

endmodule
